// File: rtl/apb_slave_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : apb_slave_bank                                            |
// | Brief    : APB slave with NUM_SLAVES register banks and counters.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module apb_slave_bank #(
  parameter int NUM_SLAVES  = 3,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  pwrite,
  input  logic                  penable,
  input  logic [NUM_SLAVES-1:0] pselx,
  input  logic [31:0]           paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [CNT_W-1:0]      wr_cnt,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int                    c_ADDR_W = $clog2(DEPTH);
  localparam logic [3:0]            c_WAIT   = 4'(WAIT_CYCLES);
  localparam logic [NUM_SLAVES-1:0] c_ONE    = NUM_SLAVES'(1);
  localparam logic [0:0]            c_IDLE   = 1'b0;
  localparam logic [0:0]            c_ACCESS = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [3:0]            r_wait_cnt;
  logic [c_ADDR_W-1:0]   r_idx;
  logic                  r_write;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [CNT_W-1:0]      r_err_cnt;

  logic [c_ADDR_W-1:0]   w_idx;
  logic                  w_any_sel;
  logic                  w_setup;
  logic                  w_onehot;
  logic                  w_match;
  logic                  w_ready;
  logic                  w_err;
  logic                  w_load;
  logic                  w_dec;
  logic                  w_good_wr;
  logic                  w_good_rd;
  logic [31:0]           w_rd_data;
  logic [31:0]           w_bank_rd [NUM_SLAVES];
  logic                  w_unused_paddr;

  assign w_idx          = paddr[c_ADDR_W+1:2];
  assign w_unused_paddr = &{1'b0, paddr[31:c_ADDR_W+2], paddr[1:0]};
  assign w_any_sel      = |pselx;
  assign w_setup        = w_any_sel & ~penable;
  assign w_onehot       = w_any_sel && ((pselx & (pselx - c_ONE)) == '0);
  assign w_match        = (w_idx == r_idx) && (pwrite == r_write) && (pselx == r_sel);
  assign w_good_wr      = w_ready & ~w_err & pwrite;
  assign w_good_rd      = w_ready & ~w_err & ~pwrite;

  // FSM: state register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_setup) w_state_nxt = c_ACCESS;
      end
      c_ACCESS: begin
        if (!w_any_sel)              w_state_nxt = c_IDLE;
        else if (w_setup)            w_state_nxt = c_ACCESS;
        else if (r_wait_cnt == 4'd0) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM: outputs; an enable without a preceding setup completes with an error
  always_comb begin
    w_ready = 1'b0;
    w_err   = 1'b0;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_setup) begin
          w_load = 1'b1;
        end else if (w_any_sel && penable) begin
          w_ready = 1'b1;
          w_err   = 1'b1;
        end
      end
      c_ACCESS: begin
        if (w_setup) begin
          w_load = 1'b1;
        end else if (w_any_sel) begin
          if (r_wait_cnt != 4'd0) begin
            w_dec = 1'b1;
          end else begin
            w_ready = 1'b1;
            w_err   = !w_onehot || !w_match;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_sel      <= '0;
    end else if (w_load) begin
      r_wait_cnt <= c_WAIT;
      r_idx      <= w_idx;
      r_write    <= pwrite;
      r_sel      <= pselx;
    end else if (w_dec) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Counters stick at all-ones instead of wrapping
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_good_wr && (r_wr_cnt != '1))          r_wr_cnt  <= r_wr_cnt + 1'b1;
      if (w_good_rd && (r_rd_cnt != '1))          r_rd_cnt  <= r_rd_cnt + 1'b1;
      if (w_ready && w_err && (r_err_cnt != '1))  r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bank
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_good_wr && pselx[g]) begin
        r_mem[w_idx] <= pwdata;
      end
    end

    assign w_bank_rd[g] = r_mem[w_idx];
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (pselx[i]) w_rd_data = w_rd_data | w_bank_rd[i];
    end
  end

  // Reset gates the outputs so they drop without waiting for a clock edge
  always_comb begin
    pready  = w_ready & Hresetn;
    pslverr = w_ready & w_err & Hresetn;
    prdata  = (w_ready && Hresetn && !w_err && !pwrite) ? w_rd_data : 32'h0;
  end

  assign wr_cnt  = r_wr_cnt;
  assign rd_cnt  = r_rd_cnt;
  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_apb_slave_bank                                         |
// | Brief    : Scoreboard bench for apb_slave_bank (0 and 3 wait states).|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_apb_slave_bank;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
    int          wc;
    int          rc;
    int          ec;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n   [2];
  logic        pwrite  [2];
  logic        penable [2];
  logic [2:0]  pselx   [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [3:0]  wc_a, rc_a, ec_a;
  logic [15:0] wc_b, rc_b, ec_b;
  int          wc_o [2];
  int          rc_o [2];
  int          ec_o [2];

  always_comb begin
    wc_o[0] = int'(wc_a);
    rc_o[0] = int'(rc_a);
    ec_o[0] = int'(ec_a);
    wc_o[1] = int'(wc_b);
    rc_o[1] = int'(rc_b);
    ec_o[1] = int'(ec_b);
  end

  apb_slave_bank #(.NUM_SLAVES(3), .DEPTH(16), .WAIT_CYCLES(0), .CNT_W(4)) dut_a (
    .Hclk(clk), .Hresetn(rst_n[0]), .pwrite(pwrite[0]), .penable(penable[0]),
    .pselx(pselx[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]),
    .wr_cnt(wc_a), .rd_cnt(rc_a), .err_cnt(ec_a)
  );

  apb_slave_bank #(.NUM_SLAVES(3), .DEPTH(16), .WAIT_CYCLES(3), .CNT_W(16)) dut_b (
    .Hclk(clk), .Hresetn(rst_n[1]), .pwrite(pwrite[1]), .penable(penable[1]),
    .pselx(pselx[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]),
    .wr_cnt(wc_b), .rd_cnt(rc_b), .err_cnt(ec_b)
  );

  // Reference model: plain storage arrays and counters per instance
  logic [31:0] mem_m [2][3][16];
  int          wc_m [2];
  int          rc_m [2];
  int          ec_m [2];
  exp_t        q    [2][$];
  logic        pend [2];
  exp_t        pc   [2];
  int          total = 0;
  int          bad   = 0;

  function automatic int wt(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int cmax(int d);
    return (d == 0) ? 15 : 65535;
  endfunction

  function automatic int sat(int v, int d);
    return (v < cmax(d)) ? v + 1 : v;
  endfunction

  function automatic int bank(logic [2:0] s);
    return s[0] ? 0 : (s[1] ? 1 : 2);
  endfunction

  function automatic logic onehot(logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
  endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h (cycle %0d)", name, d, act, expv, cyc);
    end
  endtask

  task automatic clear_model(int d);
    for (int b = 0; b < 3; b++)
      for (int w = 0; w < 16; w++) mem_m[d][b][w] = 32'h0;
    wc_m[d] = 0;
    rc_m[d] = 0;
    ec_m[d] = 0;
  endtask

  task automatic drv(int d, logic [2:0] s, logic en, logic [31:0] a, logic w, logic [31:0] wd);
    @(posedge clk);
    #1;
    pselx[d]   = s;
    penable[d] = en;
    paddr[d]   = a;
    pwrite[d]  = w;
    pwdata[d]  = wd;
  endtask

  task automatic push_exp(int d, logic err, logic [31:0] data);
    exp_t e;
    e.cyc  = cyc;
    e.err  = err;
    e.data = data;
    e.wc   = wc_m[d];
    e.rc   = rc_m[d];
    e.ec   = ec_m[d];
    q[d].push_back(e);
  endtask

  // mut: 0 none, 1 word index +1, 2 pwrite flipped, 3 different select
  task automatic xfer(int d, logic [2:0] s, logic [31:0] a, logic w, logic [31:0] wd, int mut);
    logic [2:0]  s2;
    logic [31:0] a2;
    logic        w2;
    logic        err;
    logic [31:0] data;
    int          idx;
    s2  = s;
    a2  = a;
    w2  = w;
    idx = int'(a[5:2]);
    drv(d, s, 1'b0, a, w, wd);
    for (int k = 0; k <= wt(d); k++) begin
      if (mut != 0 && k == ((wt(d) > 0) ? 1 : 0)) begin
        case (mut)
          1:       a2[5:2] = a[5:2] + 4'd1;
          2:       w2 = ~w;
          default: s2 = (s == 3'b001) ? 3'b010 : 3'b001;
        endcase
      end
      drv(d, s2, 1'b1, a2, w2, wd);
    end
    err  = !onehot(s2) || (mut != 0);
    data = (!err && !w) ? mem_m[d][bank(s)][idx] : 32'h0;
    if (!err && w) mem_m[d][bank(s)][idx] = wd;
    if (err)      ec_m[d] = sat(ec_m[d], d);
    else if (w)   wc_m[d] = sat(wc_m[d], d);
    else          rc_m[d] = sat(rc_m[d], d);
    push_exp(d, err, data);
  endtask

  task automatic noset(int d, logic [2:0] s);
    drv(d, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    drv(d, s, 1'b1, 32'h4, 1'b1, 32'h99);
    ec_m[d] = sat(ec_m[d], d);
    push_exp(d, 1'b1, 32'h0);
    drv(d, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rand_mix(int d, int n);
    for (int i = 0; i < n; i++) begin
      int          r;
      int          mut;
      logic [2:0]  s;
      logic [31:0] a;
      r   = $urandom_range(0, 9);
      s   = (r < 8) ? (3'b001 << (r % 3)) : 3'($urandom_range(1, 7));
      mut = ($urandom_range(0, 7) < 6) ? 0 : $urandom_range(1, 3);
      a   = $urandom;
      a[5:2] = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) noset(d, s);
      else xfer(d, s, a, 1'($urandom_range(0, 1)), $urandom, mut);
    end
  endtask

  // Monitor: pops the scoreboard whenever a completion is presented
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pend[d]) begin
        pend[d] = 1'b0;
        chk("wr_cnt", d, wc_o[d], pc[d].wc);
        chk("rd_cnt", d, rc_o[d], pc[d].rc);
        chk("err_cnt", d, ec_o[d], pc[d].ec);
      end
      if (pready[d] === 1'b1) begin
        if (q[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_ready dut%0d: got pready=1 want 0 (cycle %0d)", d, cyc);
        end else begin
          exp_t e;
          e = q[d].pop_front();
          chk("ready_cycle", d, cyc, e.cyc);
          chk("pslverr", d, {31'h0, pslverr[d]}, {31'h0, e.err});
          chk("prdata", d, prdata[d], e.data);
          pc[d]   = e;
          pend[d] = 1'b1;
        end
      end else begin
        chk("idle_pslverr", d, {31'h0, pslverr[d]}, 32'h0);
        chk("idle_prdata", d, prdata[d], 32'h0);
        if (q[d].size() > 0 && q[d][0].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL missing_ready dut%0d: got pready=0 want 1 at cycle %0d", d, q[d][0].cyc);
          void'(q[d].pop_front());
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]   = 1'b0;
      pselx[d]   = 3'b000;
      penable[d] = 1'b0;
      paddr[d]   = 32'h0;
      pwrite[d]  = 1'b0;
      pwdata[d]  = 32'h0;
      pend[d]    = 1'b0;
      clear_model(d);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_pready", d, {31'h0, pready[d]}, 32'h0);
      chk("rst_wr_cnt", d, wc_o[d], 0);
      chk("rst_err_cnt", d, ec_o[d], 0);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Zero wait states, 4-bit counters
    xfer(0, 3'b010, 32'h8, 1'b1, 32'hDEADBEEF, 0);
    xfer(0, 3'b010, 32'h8, 1'b0, 32'h0, 0);
    xfer(0, 3'b011, 32'h0, 1'b1, 32'h55, 0);
    xfer(0, 3'b001, 32'h0, 1'b0, 32'h0, 0);
    xfer(0, 3'b010, 32'h0, 1'b0, 32'h0, 0);
    noset(0, 3'b100);
    for (int i = 0; i < 17; i++)
      xfer(0, 3'b001 << $urandom_range(0, 2), $urandom, 1'b1, $urandom, 0);
    rand_mix(0, 40);
    drv(0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);

    // Three wait states
    xfer(1, 3'b001, 32'h14, 1'b1, 32'h12345678, 0);
    xfer(1, 3'b001, 32'h14, 1'b0, 32'h0, 0);
    xfer(1, 3'b001, 32'h4, 1'b1, 32'hA5A5A5A5, 1);
    xfer(1, 3'b001, 32'h4, 1'b0, 32'h0, 0);
    xfer(1, 3'b001, 32'h8, 1'b0, 32'h0, 0);
    noset(1, 3'b010);

    // Abort mid-wait leaves storage untouched
    xfer(1, 3'b010, 32'h1C, 1'b1, 32'h1111, 0);
    drv(1, 3'b010, 1'b0, 32'h1C, 1'b1, 32'h2222);
    drv(1, 3'b010, 1'b1, 32'h1C, 1'b1, 32'h2222);
    drv(1, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    xfer(1, 3'b010, 32'h1C, 1'b0, 32'h0, 0);

    // New setup during a wait state replaces the pending transfer
    drv(1, 3'b100, 1'b0, 32'hC, 1'b1, 32'h3333);
    drv(1, 3'b100, 1'b1, 32'hC, 1'b1, 32'h3333);
    xfer(1, 3'b100, 32'h10, 1'b1, 32'h4444, 0);
    xfer(1, 3'b100, 32'hC, 1'b0, 32'h0, 0);
    xfer(1, 3'b100, 32'h10, 1'b0, 32'h0, 0);
    rand_mix(1, 30);

    // Reset in the middle of a wait-state write
    xfer(1, 3'b001, 32'h18, 1'b1, 32'h7777, 0);
    drv(1, 3'b001, 1'b0, 32'h18, 1'b1, 32'h8888);
    drv(1, 3'b001, 1'b1, 32'h18, 1'b1, 32'h8888);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("async_rst_pready", 1, {31'h0, pready[1]}, 32'h0);
    chk("async_rst_pslverr", 1, {31'h0, pslverr[1]}, 32'h0);
    chk("async_rst_prdata", 1, prdata[1], 32'h0);
    chk("async_rst_wr_cnt", 1, wc_o[1], 0);
    chk("async_rst_rd_cnt", 1, rc_o[1], 0);
    chk("async_rst_err_cnt", 1, ec_o[1], 0);
    pselx[1]   = 3'b000;
    penable[1] = 1'b0;
    clear_model(1);
    @(posedge clk);
    #2;
    rst_n[1] = 1'b1;
    xfer(1, 3'b001, 32'h18, 1'b0, 32'h0, 0);
    drv(1, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 0, q[0].size(), 0);
    chk("queue_drained", 1, q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
